// File: rtl/negator_unit.sv
// negator_unit
//   Multi-cycle complement unit. One operand is accepted through a
//   valid/ready handshake. The unit produces bitwise NOT, two's-complement
//   negation, absolute value or pass-through. The carry chain is walked CHUNK
//   bits per cycle, starting with the least-significant chunk, so the adder
//   depth stays bounded at CHUNK bits. The result is held until consumed.
//
//   Optional feature macro: NEG_ABS_MODE_EN
//     defined   : MODE 2'b10 computes the absolute value.
//     undefined : MODE 2'b10 behaves as pass-through (MODE 2'b11), OVF = 0.
//
//   Parameters
//     WIDTH : operand/result width, must be a multiple of CHUNK
//     CHUNK : bits processed per BUSY cycle (N = WIDTH/CHUNK cycles)
//
//   Ports
//     CLK       in   rising-edge clock
//     RST       in   asynchronous active-high reset
//     IN_VALID  in   operand/mode present
//     IN_READY  out  unit can accept (IDLE only)
//     IN        in   operand
//     MODE      in   00 NOT, 01 NEG, 10 ABS, 11 PASS
//     OUT_VALID out  result valid (DONE)
//     OUT_READY in   consumer takes the result
//     Y         out  registered result
//     OVF       out  NEG/ABS of the most-negative value
//     ZERO      out  Y == 0
module negator_unit #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN,
  input  logic [1:0]       MODE,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] Y,
  output logic             OVF,
  output logic             ZERO
);

  localparam int unsigned N     = WIDTH / CHUNK;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N - 1);
  localparam logic [WIDTH-1:0] MOST_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] CHUNK_MASK = ~({WIDTH{1'b1}} << CHUNK);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  // ABS is resolved to NEG or PASS at capture time using the operand sign,
  // so the chunk datapath only ever sees three operations.
  typedef enum logic [1:0] {
    OP_NOT,
    OP_NEG,
    OP_PASS
  } op_t;

  state_t           state_q;
  op_t              op_q;
  op_t              op_in;
  logic [WIDTH-1:0] opnd_q;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] y_q;
  logic             ovf_q;
  logic             zero_q;

  int unsigned      base;
  logic [CHUNK-1:0] chunk_in;
  logic [CHUNK-1:0] chunk_out;
  logic [CHUNK:0]   sum;
  logic [WIDTH-1:0] y_next;
  logic             ovf_next;

  // Decode the requested mode into the effective operation.
  always_comb begin
    op_in = OP_PASS;
    case (MODE)
      2'b00:   op_in = OP_NOT;
      2'b01:   op_in = OP_NEG;
`ifdef NEG_ABS_MODE_EN
      2'b10:   op_in = IN[WIDTH-1] ? OP_NEG : OP_PASS;
`else
      2'b10:   op_in = OP_PASS;
`endif
      default: op_in = OP_PASS;
    endcase
  end

  // One chunk of the result. Selection and insertion use shifts and masks
  // so the chunk position can be a plain integer index.
  always_comb begin
    base      = CHUNK * 32'(idx_q);
    chunk_in  = CHUNK'(opnd_q >> base);
    sum       = {1'b0, ~chunk_in} + {{CHUNK{1'b0}}, carry_q};
    chunk_out = chunk_in;
    case (op_q)
      OP_NOT:  chunk_out = ~chunk_in;
      OP_NEG:  chunk_out = sum[CHUNK-1:0];
      default: chunk_out = chunk_in;
    endcase
    y_next   = (y_q & ~(CHUNK_MASK << base)) | (WIDTH'(chunk_out) << base);
    ovf_next = (op_q == OP_NEG) && (opnd_q == MOST_NEG);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOT;
      opnd_q  <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      y_q     <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (IN_VALID) begin
            opnd_q  <= IN;
            op_q    <= op_in;
            idx_q   <= '0;
            carry_q <= 1'b1;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          y_q     <= y_next;
          // Carry out of the top chunk is naturally dropped here: the next
          // operation reloads the carry on capture.
          carry_q <= sum[CHUNK];
          if (idx_q == LAST_IDX) begin
            ovf_q   <= ovf_next;
            zero_q  <= (y_next == '0);
            state_q <= S_DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_DONE: begin
          if (OUT_READY) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign IN_READY  = (state_q == S_IDLE);
  assign OUT_VALID = (state_q == S_DONE);
  assign Y         = y_q;
  assign OVF       = ovf_q;
  assign ZERO      = zero_q;

endmodule
